id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage RV32I core, between decode and execute.
- Registers decode outputs into the execute stage and drives rs1_x/rs2_x to the forwarding unit.
- Detects load-use hazards, which forwarding cannot resolve, and inserts a one-cycle bubble while stalling fetch and decode.
- Applies branch-flush and external-hold control, and keeps a saturating load-use stall counter.

Parameters:
XLEN, 32, datapath width of register data, immediate and PC
CNT_W, 16, width of the load-use stall counter

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
valid_D  in  1  decode slot holds a real instruction
pc_D  in  XLEN  PC of decode instruction
rs1_D  in  5  source register 1 index
rs2_D  in  5  source register 2 index
uses_rs1_D  in  1  instruction reads rs1
uses_rs2_D  in  1  instruction reads rs2
rd_D  in  5  destination register index
rdata1_D  in  XLEN  register file read data 1
rdata2_D  in  XLEN  register file read data 2
imm_D  in  XLEN  decoded immediate
alu_op_D  in  4  ALU operation
reg_write_en_D  in  1  instruction writes rd
mem_read_D  in  1  instruction is a load
ctrl_D  in  6  remaining control {mem_write, branch, jump, alu_src, wb_sel[1:0]}
flush_E  in  1  branch/jump taken in EX; squash decode and ID/EX
hold  in  1  external freeze (memory wait)
valid_x, pc_x, rs1_x, rs2_x, rd_x, rdata1_x, rdata2_x, imm_x, alu_op_x, reg_write_en_x, mem_read_x, ctrl_x  out  same widths as the _D ports  registered execute-stage fields
stall_F  out  1  hold PC
stall_D  out  1  hold IF/ID register
load_use_cnt  out  CNT_W  saturating count of inserted load-use bubbles

Behaviour:
- Reset (rst_n=0, asynchronous): every _x output is 0 and load_use_cnt is 0.
  - valid_x, reg_write_en_x, mem_read_x and ctrl_x are 0, so the slot is a bubble.
  - Release takes effect on the first clk edge after rst_n rises.
- Combinational hazard detection: load_use = valid_x & mem_read_x & (rd_x!=0) & valid_D & ((uses_rs1_D & rs1_D==rd_x) | (uses_rs2_D & rs2_D==rd_x)).
- stall_F = stall_D = load_use & ~flush_E. These outputs are combinational and are not gated by hold.
- Register update on each rising edge, priority highest first:
  - flush_E=1: load a bubble. All _x fields become 0, including data fields, so bubbles are deterministic.
  - else hold=1: all _x fields keep their values. The counter does not change.
  - else load_use=1: load a bubble (same zeroing as flush) and increment load_use_cnt.
  - else: copy every _D input to its _x output. valid_x = valid_D.
- Counter saturation: load_use_cnt increments only in the load_use branch above. It saturates at 2^CNT_W-1 and never wraps.
- Latency: 1 cycle from a _D input to its _x output.
- Load-use penalty:
  - The stall lasts exactly one cycle.
  - After the bubble, mem_read_x=0, so load_use clears.
  - The held decode instruction enters EX on the next edge, and MEM→EX forwarding supplies the loaded value.
- rd_x=0 never causes a stall. A load into x0 is architecturally dead.
- flush_E together with load_use: the flush wins, stall_F and stall_D stay low, and the counter is unchanged.
- hold together with load_use: the register freezes, stall_F and stall_D stay high, and the counter is unchanged. The condition is re-evaluated every cycle, so when hold drops the bubble and count happen once.
- Reset mid-stall: all outputs clear immediately, and stall_F/stall_D drop because valid_x=0.

Test Plan:
1. Reset, then a stream with no loads (add x3,x1,x2 at pc 0x100) → pc_x=0x100, rs1_x=1, rs2_x=2, rd_x=3 one cycle later; stall_F stays 0.
2. lw x5 in EX (mem_read_x=1, rd_x=5) with decode add x6,x5,x7 (uses_rs1_D=1) → stall_F=stall_D=1 for one cycle; next edge gives valid_x=0 and load_use_cnt=1; the following edge gives rd_x=6, rs1_x=5.
3. lw x0 in EX with decode reading x0 → no stall, and load_use_cnt stays 0.
4. Load-use on rs2 with uses_rs2_D=0 (I-type) → no stall.
5. Load-use and flush_E asserted in the same cycle → stall_F=0, next edge gives valid_x=0 and load_use_cnt unchanged. Separately, hold=1 for 3 cycles during load-use → _x fields frozen and stall_F=1 throughout; after hold drops, exactly one bubble and load_use_cnt+=1.
6. CNT_W=2 with 5 load-use bubbles → load_use_cnt reads 1,2,3,3,3. Assert rst_n=0 mid-stall → all outputs 0 asynchronously.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// -----------------------------------------------------------------------------
// id_ex_stage_if
// Bundle between the decode stage, the ID/EX pipeline register and the
// execute stage / forwarding unit.
//
//   Decode side (_D) : valid, pc, rs1/rs2 indices and read enables, rd,
//                      register file read data, immediate, alu_op,
//                      reg_write_en, mem_read, ctrl
//   Pipeline control : flush_E (taken branch/jump in EX), hold (freeze)
//   Execute side (_x): registered copies of the decode fields
//   Status           : stall_F, stall_D, load_use_cnt
//
// Modports
//   master : the surrounding core (drives decode fields and control)
//   slave  : the ID/EX stage itself
// -----------------------------------------------------------------------------
interface id_ex_stage_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    // Decode-stage fields
    logic            valid_D;
    logic [XLEN-1:0] pc_D;
    logic [4:0]      rs1_D;
    logic [4:0]      rs2_D;
    logic            uses_rs1_D;
    logic            uses_rs2_D;
    logic [4:0]      rd_D;
    logic [XLEN-1:0] rdata1_D;
    logic [XLEN-1:0] rdata2_D;
    logic [XLEN-1:0] imm_D;
    logic [3:0]      alu_op_D;
    logic            reg_write_en_D;
    logic            mem_read_D;
    logic [5:0]      ctrl_D;  // {mem_write, branch, jump, alu_src, wb_sel[1:0]}

    // Pipeline control
    logic            flush_E;
    logic            hold;

    // Execute-stage fields
    logic            valid_x;
    logic [XLEN-1:0] pc_x;
    logic [4:0]      rs1_x;
    logic [4:0]      rs2_x;
    logic [4:0]      rd_x;
    logic [XLEN-1:0] rdata1_x;
    logic [XLEN-1:0] rdata2_x;
    logic [XLEN-1:0] imm_x;
    logic [3:0]      alu_op_x;
    logic            reg_write_en_x;
    logic            mem_read_x;
    logic [5:0]      ctrl_x;

    // Hazard status
    logic            stall_F;
    logic            stall_D;
    logic [CNT_W-1:0] load_use_cnt;

    modport master (
        output valid_D, pc_D, rs1_D, rs2_D, uses_rs1_D, uses_rs2_D, rd_D,
               rdata1_D, rdata2_D, imm_D, alu_op_D, reg_write_en_D,
               mem_read_D, ctrl_D, flush_E, hold,
        input  valid_x, pc_x, rs1_x, rs2_x, rd_x, rdata1_x, rdata2_x, imm_x,
               alu_op_x, reg_write_en_x, mem_read_x, ctrl_x,
               stall_F, stall_D, load_use_cnt
    );

    modport slave (
        input  valid_D, pc_D, rs1_D, rs2_D, uses_rs1_D, uses_rs2_D, rd_D,
               rdata1_D, rdata2_D, imm_D, alu_op_D, reg_write_en_D,
               mem_read_D, ctrl_D, flush_E, hold,
        output valid_x, pc_x, rs1_x, rs2_x, rd_x, rdata1_x, rdata2_x, imm_x,
               alu_op_x, reg_write_en_x, mem_read_x, ctrl_x,
               stall_F, stall_D, load_use_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register of the 5-stage RV32I core. Registers the decode
// fields into the execute stage, detects load-use hazards (which forwarding
// cannot cover) and inserts a one-cycle bubble while stalling fetch/decode.
// Branch flush squashes the slot, hold freezes it, and a saturating counter
// records how many load-use bubbles were inserted.
//
// Ports
//   clk   : core clock, rising edge
//   rst_n : asynchronous active-low reset; clears every _x field and counter
//   bus   : id_ex_stage_if.slave -- decode fields in, execute fields out,
//           flush_E/hold in, stall_F/stall_D/load_use_cnt out
// -----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    id_ex_stage_if.slave  bus
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] rdata1;
        logic [XLEN-1:0] rdata2;
        logic [XLEN-1:0] imm;
        logic [3:0]      alu_op;
        logic            reg_write_en;
        logic            mem_read;
        logic [5:0]      ctrl;
    } ex_fields_t;

    ex_fields_t       ex_q, ex_d;
    ex_fields_t       dec_fields;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use;
    logic             rs1_match;
    logic             rs2_match;

    assign dec_fields = '{
        valid:        bus.valid_D,
        pc:           bus.pc_D,
        rs1:          bus.rs1_D,
        rs2:          bus.rs2_D,
        rd:           bus.rd_D,
        rdata1:       bus.rdata1_D,
        rdata2:       bus.rdata2_D,
        imm:          bus.imm_D,
        alu_op:       bus.alu_op_D,
        reg_write_en: bus.reg_write_en_D,
        mem_read:     bus.mem_read_D,
        ctrl:         bus.ctrl_D
    };

    // A load into x0 is architecturally dead, so rd_x == 0 never stalls.
    assign rs1_match = bus.uses_rs1_D && (bus.rs1_D == ex_q.rd);
    assign rs2_match = bus.uses_rs2_D && (bus.rs2_D == ex_q.rd);
    assign load_use  = ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) &&
                       bus.valid_D && (rs1_match || rs2_match);

    // Not gated by hold: the decode instruction must stay put while frozen.
    assign bus.stall_F = load_use && !bus.flush_E;
    assign bus.stall_D = load_use && !bus.flush_E;

    // Priority: flush > hold > load-use bubble > normal advance.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        ex_d  = dec_fields;
        cnt_d = cnt_q;
        if (bus.flush_E) begin
            ex_d = '0;  // data fields zeroed too, so bubbles are deterministic
        end else if (bus.hold) begin
            ex_d = ex_q;
        end else if (load_use) begin
            ex_d = '0;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments here so all registers sample the
            // pre-edge values, independent of statement order.
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.valid_x        = ex_q.valid;
    assign bus.pc_x           = ex_q.pc;
    assign bus.rs1_x          = ex_q.rs1;
    assign bus.rs2_x          = ex_q.rs2;
    assign bus.rd_x           = ex_q.rd;
    assign bus.rdata1_x       = ex_q.rdata1;
    assign bus.rdata2_x       = ex_q.rdata2;
    assign bus.imm_x          = ex_q.imm;
    assign bus.alu_op_x       = ex_q.alu_op;
    assign bus.reg_write_en_x = ex_q.reg_write_en;
    assign bus.mem_read_x     = ex_q.mem_read;
    assign bus.ctrl_x         = ex_q.ctrl;
    assign bus.load_use_cnt   = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
// Directed bench for id_ex_stage with a small counter width so saturation is
// reachable. Expected execute-stage contents are pushed to a scoreboard queue
// when the decode inputs are driven and popped after the next rising edge.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 2;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] rdata1;
        logic [XLEN-1:0] rdata2;
        logic [XLEN-1:0] imm;
        logic [3:0]      alu_op;
        logic            reg_write_en;
        logic            mem_read;
        logic [5:0]      ctrl;
    } ex_t;

    logic clk;
    logic rst_n;

    id_ex_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  n_checks = 0;
    int  n_passed = 0;
    ex_t sb[$];
    ex_t cur_x;   // expected contents of the execute slot right now

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_checks++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic ex_t x_fields();
        return '{bus.valid_x, bus.pc_x, bus.rs1_x, bus.rs2_x, bus.rd_x,
                 bus.rdata1_x, bus.rdata2_x, bus.imm_x, bus.alu_op_x,
                 bus.reg_write_en_x, bus.mem_read_x, bus.ctrl_x};
    endfunction

    function automatic ex_t d_fields();
        return '{bus.valid_D, bus.pc_D, bus.rs1_D, bus.rs2_D, bus.rd_D,
                 bus.rdata1_D, bus.rdata2_D, bus.imm_D, bus.alu_op_D,
                 bus.reg_write_en_D, bus.mem_read_D, bus.ctrl_D};
    endfunction

    // Drive one decode instruction; data fields get fresh random values.
    task automatic drive(input logic [XLEN-1:0] pc, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic u1, input logic u2,
                         input logic [4:0] rd, input logic mr);
        bus.valid_D        = 1'b1;
        bus.pc_D           = pc;
        bus.rs1_D          = rs1;
        bus.rs2_D          = rs2;
        bus.uses_rs1_D     = u1;
        bus.uses_rs2_D     = u2;
        bus.rd_D           = rd;
        bus.rdata1_D       = $urandom;
        bus.rdata2_D       = $urandom;
        bus.imm_D          = $urandom;
        bus.alu_op_D       = 4'($urandom_range(0, 15));
        bus.reg_write_en_D = 1'b1;
        bus.mem_read_D     = mr;
        bus.ctrl_D         = mr ? 6'b000001 : 6'b000000;
    endtask

    task automatic push_copy();   sb.push_back(d_fields()); endtask
    task automatic push_bubble(); sb.push_back('0);         endtask
    task automatic push_hold();   sb.push_back(cur_x);      endtask

    // Entered just after a falling edge with inputs driven and an expectation
    // queued: check the combinational stalls, clock once, check the slot.
    task automatic cycle(input string tag, input logic exp_stall, input logic [CNT_W-1:0] exp_cnt);
        ex_t exp;
        #1;
        check({tag, "_stall_F"}, 160'(bus.stall_F), 160'(exp_stall));
        check({tag, "_stall_D"}, 160'(bus.stall_D), 160'(exp_stall));
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 160'(0), 160'(1));
        end else begin
            exp = sb.pop_front();
            check({tag, "_x"}, 160'(x_fields()), 160'(exp));
            cur_x = exp;
        end
        check({tag, "_cnt"}, 160'(bus.load_use_cnt), 160'(exp_cnt));
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_x"},       160'(x_fields()),         160'(0));
        check({tag, "_cnt"},     160'(bus.load_use_cnt),   160'(0));
        check({tag, "_stall_F"}, 160'(bus.stall_F),        160'(0));
        check({tag, "_stall_D"}, 160'(bus.stall_D),        160'(0));
    endtask

    initial begin : stimulus
        logic [CNT_W-1:0] sat_cnt;
        rst_n = 1'b0;
        cur_x = '0;
        bus.valid_D = 1'b0; bus.pc_D = '0; bus.rs1_D = '0; bus.rs2_D = '0;
        bus.uses_rs1_D = 1'b0; bus.uses_rs2_D = 1'b0; bus.rd_D = '0;
        bus.rdata1_D = '0; bus.rdata2_D = '0; bus.imm_D = '0; bus.alu_op_D = '0;
        bus.reg_write_en_D = 1'b0; bus.mem_read_D = 1'b0; bus.ctrl_D = '0;
        bus.flush_E = 1'b0; bus.hold = 1'b0;

        // Reset state
        #2;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: add x3,x1,x2 at 0x100
        drive(32'h100, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0);
        push_copy();
        cycle("t1_add", 1'b0, 2'd0);
        check("t1_pc_x", 160'(bus.pc_x), 160'(32'h100));
        check("t1_regs", 160'({bus.rs1_x, bus.rs2_x, bus.rd_x}), 160'({5'd1, 5'd2, 5'd3}));

        // 2: lw x5, then add x6,x5,x7 -> one bubble, then the add enters EX
        drive(32'h104, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1);
        push_copy();
        cycle("t2_lw", 1'b0, 2'd0);
        drive(32'h108, 5'd5, 5'd7, 1'b1, 1'b1, 5'd6, 1'b0);
        push_bubble();
        cycle("t2_bubble", 1'b1, 2'd1);
        push_copy();
        cycle("t2_add", 1'b0, 2'd1);
        check("t2_rd_rs1", 160'({bus.rd_x, bus.rs1_x}), 160'({5'd6, 5'd5}));

        // 3: lw x0 followed by a reader of x0 -> no stall
        drive(32'h10c, 5'd2, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1);
        push_copy();
        cycle("t3_lw_x0", 1'b0, 2'd1);
        drive(32'h110, 5'd0, 5'd0, 1'b1, 1'b1, 5'd7, 1'b0);
        push_copy();
        cycle("t3_use_x0", 1'b0, 2'd1);

        // 4: rs2 field matches the load but is unused (I-type) -> no stall
        drive(32'h114, 5'd2, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1);
        push_copy();
        cycle("t4_lw", 1'b0, 2'd1);
        drive(32'h118, 5'd1, 5'd8, 1'b1, 1'b0, 5'd9, 1'b0);
        push_copy();
        cycle("t4_itype", 1'b0, 2'd1);

        // 5a: load-use together with flush -> flush wins, no count
        drive(32'h11c, 5'd1, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1);
        push_copy();
        cycle("t5_lw", 1'b0, 2'd1);
        drive(32'h120, 5'd10, 5'd10, 1'b1, 1'b1, 5'd11, 1'b0);
        bus.flush_E = 1'b1;
        push_bubble();
        cycle("t5_flush", 1'b0, 2'd1);
        bus.flush_E = 1'b0;

        // 5b: hold for 3 cycles during load-use, then exactly one bubble
        drive(32'h124, 5'd1, 5'd0, 1'b1, 1'b0, 5'd12, 1'b1);
        push_copy();
        cycle("t5_lw2", 1'b0, 2'd1);
        drive(32'h128, 5'd1, 5'd12, 1'b1, 1'b1, 5'd13, 1'b0);
        bus.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_hold();
            cycle("t5_hold", 1'b1, 2'd1);
        end
        bus.hold = 1'b0;
        push_bubble();
        cycle("t5_after_hold", 1'b1, 2'd2);
        push_copy();
        cycle("t5_add", 1'b0, 2'd2);

        // 6: fresh reset, then five load-use bubbles saturate the 2-bit counter
        rst_n = 1'b0;
        #1;
        check_all_zero("t6_reset");
        cur_x = '0;
        @(negedge clk);
        rst_n = 1'b1;
        sat_cnt = '0;
        for (int i = 0; i < 5; i++) begin
            drive(32'h200 + 32'(i * 8), 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1);
            push_copy();
            cycle("t6_lw", 1'b0, sat_cnt);
            drive(32'h204 + 32'(i * 8), 5'd5, 5'd7, 1'b1, 1'b1, 5'd6, 1'b0);
            push_bubble();
            if (sat_cnt != 2'd3) sat_cnt = sat_cnt + 2'd1;
            cycle("t6_bubble", 1'b1, sat_cnt);
        end
        check("t6_saturated", 160'(bus.load_use_cnt), 160'(2'd3));

        // Reset asserted mid-stall clears everything at once
        drive(32'h300, 5'd1, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1);
        push_copy();
        cycle("t6_lw_mid", 1'b0, 2'd3);
        drive(32'h304, 5'd4, 5'd0, 1'b1, 1'b0, 5'd2, 1'b0);
        #1;
        check("t6_mid_stall", 160'(bus.stall_F), 160'(1));
        rst_n = 1'b0;
        #1;
        check_all_zero("t6_mid_reset");

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
